axi_dc_token_writer: RTL and testbench

Write-side half of a single-channel dual-clock (CDC) buffer for the AXI async slice family. It accepts a valid/ready stream in its own clock domain and stores each word in a BUFFER_DEPTH-entry register buffer. It publishes per-slot toggle tokens so a reader in a foreign clock domain can consume the words, and it tracks slot release through a synchronized copy of the reader's toggle vector. One instance feeds one AXI channel (AW, AR, W, R or B) across the async boundary, toward the matching reader half.

---
 rtl/axi_dc_token_writer_if.sv | 28 ++
 rtl/axi_dc_token_writer.sv | 76 +++++++
 tb/tb_axi_dc_token_writer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dc_token_writer_if.sv
// Write-side bundle of the dual-clock token buffer: local valid/ready stream plus
// the slot buffer and toggle vectors that cross to the reader's clock domain.
interface axi_dc_token_writer_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 8
);
  localparam int LEVEL_WIDTH = $clog2(BUFFER_DEPTH + 1);

  logic                               isolate_i;
  logic                               valid_i;
  logic                               ready_o;
  logic [DATA_WIDTH-1:0]              data_i;
  logic [DATA_WIDTH*BUFFER_DEPTH-1:0] async_data_o;
  logic [BUFFER_DEPTH-1:0]            async_writetoken_o;
  logic [BUFFER_DEPTH-1:0]            async_readpointer_i;
  logic [LEVEL_WIDTH-1:0]             level_o;
  logic                               empty_o;

  modport slave (
    input  isolate_i, valid_i, data_i, async_readpointer_i,
    output ready_o, async_data_o, async_writetoken_o, level_o, empty_o
  );

  modport master (
    output isolate_i, valid_i, data_i, async_readpointer_i,
    input  ready_o, async_data_o, async_writetoken_o, level_o, empty_o
  );
endinterface

// File: rtl/axi_dc_token_writer.sv
// CDC writer: accepted word and its slot token appear on the outputs one edge after acceptance.
// Backpressure: ready drops while isolated or while the next slot is still held by the reader.
module axi_dc_token_writer #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi_dc_token_writer_if.slave bus
);
  localparam int IDX_WIDTH   = $clog2(BUFFER_DEPTH);
  localparam int LEVEL_WIDTH = $clog2(BUFFER_DEPTH + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BUFFER_DEPTH - 1);

  logic [BUFFER_DEPTH-1:0] wr_tog;
  logic [IDX_WIDTH-1:0]    wr_idx;
  logic [DATA_WIDTH-1:0]   buf_q [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] rd_sync [SYNC_STAGES];
  logic [BUFFER_DEPTH-1:0] rd_tog_s;
  logic [BUFFER_DEPTH-1:0] occupied;
  logic [LEVEL_WIDTH-1:0]  level;
  logic                    ready;
  logic                    accept;

  // Each reader toggle bit is an independent single-bit crossing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        rd_sync[s] <= '0;
      end
    end else begin
      rd_sync[0] <= bus.async_readpointer_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        rd_sync[s] <= rd_sync[s-1];
      end
    end
  end

  assign rd_tog_s = rd_sync[SYNC_STAGES-1];
  assign occupied = wr_tog ^ rd_tog_s;

  always_comb begin
    level = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      level = level + LEVEL_WIDTH'(occupied[k]);
    end
  end

  // Slots are released in write order, so a busy wr_idx slot means the buffer is full.
  assign ready  = ~bus.isolate_i & ~occupied[wr_idx];
  assign accept = bus.valid_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_tog <= '0;
      wr_idx <= '0;
      for (int k = 0; k < BUFFER_DEPTH; k++) begin
        buf_q[k] <= '0;
      end
    end else if (accept) begin
      buf_q[wr_idx]  <= bus.data_i;
      wr_tog[wr_idx] <= ~wr_tog[wr_idx];
      wr_idx         <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_WIDTH'(1);
    end
  end

  for (genvar gk = 0; gk < BUFFER_DEPTH; gk++) begin : g_slot
    assign bus.async_data_o[gk*DATA_WIDTH +: DATA_WIDTH] = buf_q[gk];
  end

  assign bus.async_writetoken_o = wr_tog;
  assign bus.ready_o            = ready;
  assign bus.level_o            = level;
  assign bus.empty_o            = (level == '0);
endmodule

// File: tb/tb_axi_dc_token_writer.sv
`timescale 1ns/1ps
module tb_axi_dc_token_writer;
  localparam int DW = 64;
  localparam int BD = 8;
  localparam int NV = 19;

  logic clk  = 1'b0;
  logic rclk = 1'b0;
  logic rst  = 1'b1;
  real  rhalf = 15.0;

  always #5 clk = ~clk;
  initial forever #(rhalf) rclk = ~rclk;

  axi_dc_token_writer_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD)) bus ();

  axi_dc_token_writer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD), .SYNC_STAGES(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [BD-1:0] rdptr_tb = '0;
  logic [BD-1:0] rd_tog_m = '0;
  logic          rd_en = 1'b0;
  assign bus.async_readpointer_i = rd_en ? rd_tog_m : rdptr_tb;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          iso;
    logic          val;
    logic [DW-1:0] dat;
    logic [BD-1:0] rp;
    logic          rdy;
    logic [BD-1:0] tok;
    int            lvl;
    logic          emp;
    int            slot;
    logic [DW-1:0] sdat;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mk(logic iso, logic val, logic [DW-1:0] dat, logic [BD-1:0] rp,
                              logic rdy, logic [BD-1:0] tok, int lvl, logic emp,
                              int slot, logic [DW-1:0] sdat);
    vec_t v;
    v.iso = iso; v.val = val; v.dat = dat; v.rp = rp;
    v.rdy = rdy; v.tok = tok; v.lvl = lvl; v.emp = emp; v.slot = slot; v.sdat = sdat;
    return v;
  endfunction

  // Reader model on rclk: own 2-stage sync of writer tokens, in-order consumption.
  logic [DW-1:0] exp_q [$];
  int            rcv_cnt = 0;
  logic [BD-1:0] wtok_s1 = '0;
  logic [BD-1:0] wtok_s2 = '0;
  int            rd_idx_m = 0;
  int            rd_wait = 0;

  initial begin : reader
    logic [DW-1:0] got;
    forever begin
      @(posedge rclk);
      wtok_s2 = wtok_s1;
      wtok_s1 = bus.async_writetoken_o;
      if (!rd_en) begin
        rd_tog_m = '0; rd_idx_m = 0; rd_wait = 0; wtok_s1 = '0; wtok_s2 = '0;
      end else if (rd_wait != 0) begin
        rd_wait--;
      end else if (wtok_s2[rd_idx_m] != rd_tog_m[rd_idx_m]) begin
        got = bus.async_data_o[rd_idx_m*DW +: DW];
        if (exp_q.size() == 0) begin
          chk("rd_extra", got, 64'hDEAD);
        end else begin
          chk($sformatf("rd_word%0d", rcv_cnt), got, exp_q.pop_front());
        end
        rcv_cnt++;
        rd_tog_m[rd_idx_m] = ~rd_tog_m[rd_idx_m];
        rd_idx_m = (rd_idx_m == BD-1) ? 0 : rd_idx_m + 1;
        rd_wait = int'($urandom_range(0, 3));
      end
    end
  end

  // At most one token bit may change per write-clock cycle.
  logic          mon_en = 1'b0;
  logic [BD-1:0] prev_tok = '0;
  int            tok_viol = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && ($countones(prev_tok ^ bus.async_writetoken_o) > 1)) tok_viol++;
    prev_tok = bus.async_writetoken_o;
  end

  task automatic stream_round(real half, int n);
    int sent = 0;
    int guard = 0;
    int target;
    rhalf = half;
    rst = 1'b1;
    rd_en = 1'b0;
    rdptr_tb = '0;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge rclk);
    exp_q.delete();
    rcv_cnt = 0;
    tok_viol = 0;
    #2 rst = 1'b0;
    rd_en = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    while (sent < n && guard < 5000) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.data_i  = {$urandom, $urandom};
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(bus.data_i);
        sent++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.valid_i = 1'b0;
    chk("stream_sent", 64'(sent), 64'(n));
    target = sent;
    guard = 0;
    while (rcv_cnt < target && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge rclk);
    mon_en = 1'b0;
    chk("stream_drain", 64'(rcv_cnt), 64'(target));
    chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    chk("tok_step", 64'(tok_viol), 64'd0);
    rd_en = 1'b0;
    repeat (3) @(posedge rclk);
  endtask

  initial begin
    bus.isolate_i = 1'b0;
    bus.valid_i   = 1'b0;
    bus.data_i    = '0;

    for (int k = 0; k < 8; k++) begin
      vec[k] = mk(0, 1, 64'(8'h11 * (k + 1)), 8'h00, (k < 7), 8'((1 << (k + 1)) - 1),
                  k + 1, 0, k, 64'(8'h11 * (k + 1)));
    end
    vec[8]  = mk(0, 1, 64'h99, 8'h01, 0, 8'hFF, 8, 0, 0, 64'h11);
    vec[9]  = mk(0, 0, 64'h99, 8'h01, 1, 8'hFF, 7, 0, 0, 64'h11);
    vec[10] = mk(0, 1, 64'hAA, 8'h01, 0, 8'hFE, 8, 0, 0, 64'hAA);
    vec[11] = mk(0, 0, 64'h00, 8'h07, 0, 8'hFE, 8, 0, 1, 64'h22);
    vec[12] = mk(0, 0, 64'h00, 8'h07, 1, 8'hFE, 6, 0, 1, 64'h22);
    for (int k = 13; k < 18; k++) begin
      vec[k] = mk(1, 1, 64'hBB, 8'h07, 0, 8'hFE, 6, 0, 1, 64'h22);
    end
    vec[18] = mk(0, 1, 64'hBB, 8'h07, 1, 8'hFC, 7, 0, 1, 64'hBB);

    #12;
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_token", 64'(bus.async_writetoken_o), 64'd0);
    chk("rst_level", 64'(bus.level_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_data_nz", 64'(|bus.async_data_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      bus.isolate_i = vec[i].iso;
      bus.valid_i   = vec[i].val;
      bus.data_i    = vec[i].dat;
      rdptr_tb      = vec[i].rp;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.ready_o), 64'(vec[i].rdy));
      chk($sformatf("v%0d_token", i), 64'(bus.async_writetoken_o), 64'(vec[i].tok));
      chk($sformatf("v%0d_level", i), 64'(bus.level_o), 64'(vec[i].lvl));
      chk($sformatf("v%0d_empty", i), 64'(bus.empty_o), 64'(vec[i].emp));
      chk($sformatf("v%0d_slot%0d", i, vec[i].slot),
          bus.async_data_o[vec[i].slot*DW +: DW], vec[i].sdat);
    end
    bus.isolate_i = 1'b0;
    bus.valid_i   = 1'b0;
    chk("slot0_kept", bus.async_data_o[0 +: DW], 64'hAA);
    chk("slot2_kept", bus.async_data_o[2*DW +: DW], 64'h33);

    // Free slots 3 and 4 to reach level 5, then reset between clock edges.
    rdptr_tb = 8'h1F;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_level", 64'(bus.level_o), 64'd5);
    #3;
    rst = 1'b1;
    rdptr_tb = '0;
    #1;
    chk("arst_token", 64'(bus.async_writetoken_o), 64'd0);
    chk("arst_level", 64'(bus.level_o), 64'd0);
    chk("arst_empty", 64'(bus.empty_o), 64'd1);
    chk("arst_ready", 64'(bus.ready_o), 64'd1);
    chk("arst_data_nz", 64'(|bus.async_data_o), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b1;
    bus.data_i  = 64'hCC;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk("post_rst_token", 64'(bus.async_writetoken_o), 64'h01);
    chk("post_rst_slot0", bus.async_data_o[0 +: DW], 64'hCC);
    chk("post_rst_level", 64'(bus.level_o), 64'd1);

    stream_round(15.0, 24);
    stream_round(1.667, 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
